// File: rtl/qpix_serial_rx.sv
// qpix_serial_rx: receiving end of the QPix serial configuration link.
// Synchronises the gated serial clock/data stream, shifts it MSB-first into
// a WIDTH-bit register and commits the word (or DEFAULT) on load_data.
module qpix_serial_rx #(
  parameter int              WIDTH       = 32,
  parameter logic [WIDTH-1:0] DEFAULT    = '0,
  parameter int              TIMEOUT     = 1024,
  parameter int              SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ser_clk,
  input  logic             ser_data,
  input  logic             load_data,
  input  logic             sel_def,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             len_err,
  output logic             timeout_err,
  output logic [5:0]       bit_cnt,
  output logic [15:0]      word_cnt
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [5:0] CNT_FULL = 6'(WIDTH);
  localparam logic [5:0] CNT_OVER = 6'(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FULL,
    OVER
  } state_t;

  // Synchroniser chains; all four share one depth so data and sel_def stay
  // aligned with the edges detected on ser_clk and load_data.
  logic [SYNC_STAGES-1:0] clk_sync_reg;
  logic [SYNC_STAGES-1:0] data_sync_reg;
  logic [SYNC_STAGES-1:0] load_sync_reg;
  logic [SYNC_STAGES-1:0] sel_sync_reg;
  logic                   clk_prev_reg;
  logic                   load_prev_reg;

  logic                   clk_sync;
  logic                   data_sync;
  logic                   load_sync;
  logic                   sel_sync;
  logic                   clk_rise;
  logic                   load_rise;

  state_t                 state_reg;
  logic [WIDTH-1:0]       sr_reg;
  logic [5:0]             bit_cnt_reg;
  logic [5:0]             cnt_inc;
  logic [IDLE_W-1:0]      idle_cnt_reg;
  logic [WIDTH-1:0]       data_out_reg;
  logic                   data_valid_reg;
  logic                   len_err_reg;
  logic                   timeout_err_reg;
  logic [15:0]            word_cnt_reg;

  assign clk_sync  = clk_sync_reg[SYNC_STAGES-1];
  assign data_sync = data_sync_reg[SYNC_STAGES-1];
  assign load_sync = load_sync_reg[SYNC_STAGES-1];
  assign sel_sync  = sel_sync_reg[SYNC_STAGES-1];
  assign clk_rise  = clk_sync & ~clk_prev_reg;
  assign load_rise = load_sync & ~load_prev_reg;

  // Saturating bit counter increment: stops at WIDTH+1 (frame too long).
  assign cnt_inc = (bit_cnt_reg == CNT_OVER) ? bit_cnt_reg : bit_cnt_reg + 6'd1;

  // State encoding follows the bit count.
  function automatic state_t decode(input logic [5:0] cnt);
    if (cnt == 6'd0)          return IDLE;
    else if (cnt == CNT_FULL) return FULL;
    else if (cnt == CNT_OVER) return OVER;
    else                      return SHIFT;
  endfunction

  // Input synchronisers and edge-detect history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_reg  <= '0;
      data_sync_reg <= '0;
      load_sync_reg <= '0;
      sel_sync_reg  <= '0;
      clk_prev_reg  <= 1'b0;
      load_prev_reg <= 1'b0;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[SYNC_STAGES-2:0], ser_clk};
      data_sync_reg <= {data_sync_reg[SYNC_STAGES-2:0], ser_data};
      load_sync_reg <= {load_sync_reg[SYNC_STAGES-2:0], load_data};
      sel_sync_reg  <= {sel_sync_reg[SYNC_STAGES-2:0], sel_def};
      clk_prev_reg  <= clk_sync;
      load_prev_reg <= load_sync;
    end
  end

  // Frame FSM: shift, commit, length check and idle timeout. A load edge
  // takes priority over a coincident ser_clk edge, which is then dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      sr_reg          <= '0;
      bit_cnt_reg     <= '0;
      idle_cnt_reg    <= '0;
      data_out_reg    <= '0;
      data_valid_reg  <= 1'b0;
      len_err_reg     <= 1'b0;
      timeout_err_reg <= 1'b0;
      word_cnt_reg    <= '0;
    end else begin
      data_valid_reg  <= 1'b0;
      len_err_reg     <= 1'b0;
      timeout_err_reg <= 1'b0;
      if (load_rise) begin
        if (sel_sync) begin
          data_out_reg   <= DEFAULT;
          data_valid_reg <= 1'b1;
        end else if (state_reg == FULL) begin
          data_out_reg   <= sr_reg;
          data_valid_reg <= 1'b1;
          word_cnt_reg   <= word_cnt_reg + 16'd1;
        end else begin
          len_err_reg <= 1'b1;
        end
        bit_cnt_reg  <= '0;
        idle_cnt_reg <= '0;
        state_reg    <= IDLE;
      end else if (clk_rise) begin
        sr_reg       <= {sr_reg[WIDTH-2:0], data_sync};
        bit_cnt_reg  <= cnt_inc;
        idle_cnt_reg <= '0;
        state_reg    <= decode(cnt_inc);
      end else if (state_reg == SHIFT) begin
        if (idle_cnt_reg == IDLE_W'(TIMEOUT - 1)) begin
          timeout_err_reg <= 1'b1;
          bit_cnt_reg     <= '0;
          idle_cnt_reg    <= '0;
          state_reg       <= IDLE;
        end else begin
          idle_cnt_reg <= idle_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign data_out    = data_out_reg;
  assign data_valid  = data_valid_reg;
  assign len_err     = len_err_reg;
  assign timeout_err = timeout_err_reg;
  assign bit_cnt     = bit_cnt_reg;
  assign word_cnt    = word_cnt_reg;

endmodule

// File: tb/tb_qpix_serial_rx.sv
// Directed bench for qpix_serial_rx: frames, length errors, defaults,
// timeout, load/ser_clk collision, held load and mid-frame reset.
module tb_qpix_serial_rx;

  localparam int          W   = 32;
  localparam int          TO  = 1024;
  localparam int          SS  = 2;
  localparam logic [31:0] DEF = 32'hC0FFEE11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ser_clk = 1'b0;
  logic        ser_data = 1'b0;
  logic        load_data = 1'b0;
  logic        sel_def = 1'b0;
  logic [31:0] data_out;
  logic        data_valid;
  logic        len_err;
  logic        timeout_err;
  logic [5:0]  bit_cnt;
  logic [15:0] word_cnt;

  int total = 0;
  int bad = 0;

  qpix_serial_rx #(
    .WIDTH(W), .DEFAULT(DEF), .TIMEOUT(TO), .SYNC_STAGES(SS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ser_clk(ser_clk), .ser_data(ser_data),
    .load_data(load_data), .sel_def(sel_def), .data_out(data_out),
    .data_valid(data_valid), .len_err(len_err), .timeout_err(timeout_err),
    .bit_cnt(bit_cnt), .word_cnt(word_cnt)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One serial bit: 4 clk low (data set), 4 clk high; ends with ser_clk falling.
  task automatic send_bit(input logic b);
    @(negedge clk);
    ser_data = b;
    repeat (3) @(negedge clk);
    ser_clk = 1'b1;
    repeat (4) @(negedge clk);
    ser_clk = 1'b0;
  endtask

  // Send the low n bits of v, MSB first.
  task automatic send_bits(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    $display("sent %0d bits value=%h bit_cnt=%0d", n, v, bit_cnt);
  endtask

  // Load pulse with latency and pulse-width checks.
  task automatic do_load(input string tag, input logic sel, input logic exp_v, input logic exp_l);
    @(negedge clk);
    sel_def = sel;
    load_data = 1'b1;
    @(posedge clk); #1;
    check({tag, "_edge1"}, {30'd0, data_valid, len_err}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_edge2"}, {30'd0, data_valid, len_err}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_pulse"}, {30'd0, data_valid, len_err}, {30'd0, exp_v, exp_l});
    @(posedge clk); #1;
    check({tag, "_width"}, {30'd0, data_valid, len_err}, 32'd0);
    repeat (2) @(negedge clk);
    load_data = 1'b0;
    sel_def = 1'b0;
    repeat (4) @(negedge clk);
    $display("load %s sel=%0b data_out=%h word_cnt=%0d bit_cnt=%0d", tag, sel, data_out, word_cnt, bit_cnt);
  endtask

  initial begin
    #(100000 * 20);
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n_to, first_to, n_v, n_l;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_data", data_out, 32'd0);
    check("rst_flags", {29'd0, data_valid, len_err, timeout_err}, 32'd0);
    check("rst_cnts", {10'd0, bit_cnt, word_cnt}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Good frame 1
    send_bits(64'h12345678, 32);
    check("f1_bitcnt", 32'(bit_cnt), 32'd32);
    do_load("f1", 1'b0, 1'b1, 1'b0);
    check("f1_data", data_out, 32'h12345678);
    check("f1_word", 32'(word_cnt), 32'd1);
    check("f1_bitcnt0", 32'(bit_cnt), 32'd0);

    // Good frame 2
    send_bits(64'hA0A0A0AF, 32);
    do_load("f2", 1'b0, 1'b1, 1'b0);
    check("f2_data", data_out, 32'hA0A0A0AF);
    check("f2_word", 32'(word_cnt), 32'd2);

    // Short frame
    send_bits(64'hBEEF, 16);
    check("short_bitcnt", 32'(bit_cnt), 32'd16);
    do_load("short", 1'b0, 1'b0, 1'b1);
    check("short_data", data_out, 32'hA0A0A0AF);
    check("short_bitcnt0", 32'(bit_cnt), 32'd0);
    check("short_word", 32'(word_cnt), 32'd2);

    // Long frame, with saturation
    send_bits(64'h1_5555_5555, 33);
    check("long_bitcnt", 32'(bit_cnt), 32'd33);
    send_bit(1'b1);
    check("long_sat", 32'(bit_cnt), 32'd33);
    do_load("long", 1'b0, 1'b0, 1'b1);
    check("long_data", data_out, 32'hA0A0A0AF);
    check("long_bitcnt0", 32'(bit_cnt), 32'd0);

    // Default load with no bits
    do_load("def", 1'b1, 1'b1, 1'b0);
    check("def_data", data_out, DEF);
    check("def_word", 32'(word_cnt), 32'd2);

    // Timeout on a partial frame
    send_bits(64'h2AB, 10);
    check("to_bitcnt", 32'(bit_cnt), 32'd10);
    n_to = 0;
    first_to = -1;
    n_v = 0;
    n_l = 0;
    for (int j = 1; j <= TO + 10; j++) begin
      @(posedge clk); #1;
      if (timeout_err) begin
        n_to++;
        if (first_to < 0) first_to = j;
      end
      if (data_valid) n_v++;
      if (len_err) n_l++;
    end
    $display("timeout pulse at cycle %0d count=%0d", first_to, n_to);
    check("to_count", n_to, 32'd1);
    check("to_window", {31'd0, (first_to >= TO - 3) && (first_to <= TO + 1)}, 32'd1);
    check("to_other", n_v + n_l, 32'd0);
    check("to_bitcnt0", 32'(bit_cnt), 32'd0);

    // Full frame after timeout
    send_bits(64'h5A5AC3C3, 32);
    do_load("f3", 1'b0, 1'b1, 1'b0);
    check("f3_data", data_out, 32'h5A5AC3C3);
    check("f3_word", 32'(word_cnt), 32'd3);

    // 32nd ser_clk edge coincident with load; load then held 50 cycles
    send_bits(64'h0F0F0F0F, 31);
    check("col_bitcnt", 32'(bit_cnt), 32'd31);
    @(negedge clk);
    ser_data = 1'b1;
    repeat (3) @(negedge clk);
    ser_clk = 1'b1;
    load_data = 1'b1;
    n_v = 0;
    n_l = 0;
    for (int j = 0; j < 50; j++) begin
      @(posedge clk); #1;
      if (data_valid) n_v++;
      if (len_err) n_l++;
    end
    @(negedge clk);
    ser_clk = 1'b0;
    load_data = 1'b0;
    repeat (4) @(negedge clk);
    $display("collision len_err=%0d data_valid=%0d bit_cnt=%0d", n_l, n_v, bit_cnt);
    check("col_len", n_l, 32'd1);
    check("col_valid", n_v, 32'd0);
    check("col_bitcnt0", 32'(bit_cnt), 32'd0);
    check("col_data", data_out, 32'h5A5AC3C3);

    // Mid-frame reset
    send_bits(64'hABCDE, 20);
    check("rst2_pre", 32'(bit_cnt), 32'd20);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst2_data", data_out, 32'd0);
    check("rst2_cnts", {10'd0, bit_cnt, word_cnt}, 32'd0);
    check("rst2_flags", {29'd0, data_valid, len_err, timeout_err}, 32'd0);
    $display("reset asserted mid-frame data_out=%h word_cnt=%0d", data_out, word_cnt);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send_bits(64'h0000FFFF, 32);
    do_load("f4", 1'b0, 1'b1, 1'b0);
    check("f4_data", data_out, 32'h0000FFFF);
    check("f4_word", 32'(word_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qpix_serial_rx.md
Name: qpix_serial_rx

Overview:
- Receiving end of the QPix serial configuration interface, i.e. the ASIC-side counterpart of the top_rtl serial transmitters (interfaces 1 and 2).
- Deserialises the gated serial clock/data stream into a 32-bit word and commits it on the loadData one-shot, or loads defaults when selDefData is set.
- Used as an ASIC model on the bench and as a loopback checker in firmware.
- All inputs are asynchronous to clk and are synchronised internally.

Parameters:
- WIDTH, 32, serial word length in bits.
- DEFAULT, 32'h0000_0000, word committed on a load while sel_def=1.
- TIMEOUT, 1024, clk cycles with no ser_clk rising edge before a partial frame is discarded.
- SYNC_STAGES, 2, synchroniser flops per async input (minimum 2).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- ser_clk  in  1  gated serial clock from the transmitter (async).
- ser_data  in  1  serial data, MSB first, valid on ser_clk rising edge (async).
- load_data  in  1  loadData one-shot; the rising edge commits the frame (async).
- sel_def  in  1  selDefData level; sampled on the load_data edge (async).
- data_out  out  WIDTH  last committed word.
- data_valid  out  1  one-clk pulse on a good commit.
- len_err  out  1  one-clk pulse when a commit is attempted with bit count != WIDTH.
- timeout_err  out  1  one-clk pulse when a partial frame is discarded by timeout.
- bit_cnt  out  6  bits received in the current frame; saturates at WIDTH+1.
- word_cnt  out  16  good commits since reset; wraps 0xFFFF -> 0.

Behaviour:
- Reset (rst_n=0, async):
  - data_out=0, data_valid=0, len_err=0, timeout_err=0, bit_cnt=0, word_cnt=0.
  - Shift register and synchronisers cleared; state=IDLE.
- Synchronisation and edge detection:
  - ser_clk, ser_data, load_data and sel_def each pass through SYNC_STAGES flops.
  - Rising edges are detected on the synchronised ser_clk and load_data.
  - ser_data and sel_def use the same synchroniser depth, so they are aligned to their edges.
  - The transmitter must hold ser_clk high and low for at least 2 clk cycles each, and hold data stable across that window.
- Shift: on a ser_clk rising edge, sr <= {sr[WIDTH-2:0], ser_data_sync}, and bit_cnt increments, saturating at WIDTH+1.
- State machine, decoded from bit_cnt:
  - IDLE: bit_cnt=0.
  - SHIFT: 1..WIDTH-1.
  - FULL: bit_cnt=WIDTH.
  - OVER: bit_cnt=WIDTH+1.
  - In OVER, shifting continues (sr holds the last WIDTH bits) but the frame is marked bad.
- Commit on a load_data rising edge:
  - sel_def=1: data_out<=DEFAULT and data_valid pulses. word_cnt is not incremented and no length check is made.
  - sel_def=0, state FULL: data_out<=sr, data_valid pulses, word_cnt++.
  - sel_def=0, any other state (including IDLE): len_err pulses and data_out is held.
  - In every case bit_cnt<=0 and state returns to IDLE.
- Latency:
  - data_valid/len_err assert on the (SYNC_STAGES+1)th clk rising edge after the load_data pin rises.
  - data_out updates in the same cycle.
- Simultaneous ser_clk edge and load_data edge in the same clk: the load wins. It is evaluated on the pre-edge bit_cnt and the coincident bit is dropped.
- Timeout:
  - Applies in SHIFT only. An idle counter resets on every ser_clk edge.
  - When it reaches TIMEOUT: bit_cnt<=0, timeout_err pulses, state returns to IDLE.
  - FULL and OVER never time out; they wait for load_data.
- A load_data held high produces exactly one commit. Another commit requires a low level of at least 2 clk cycles.
- Reset asserted mid-frame aborts immediately. Pulses in flight are cancelled and no error is reported.
- Output pulses are exactly one clk wide. At most one of data_valid, len_err, timeout_err is high in any cycle.

Test Plan:
- Shift 32'h12345678 MSB-first (ser_clk period 8 clk), then pulse load_data -> data_out=32'h12345678, data_valid one cycle at sync+1 latency, word_cnt=1, bit_cnt=0.
- Follow with 32'hA0A0A0AF and load -> data_out=32'hA0A0A0AF, word_cnt=2; then sel_def=1 with load and no bits -> data_out=DEFAULT, data_valid=1, word_cnt stays 2.
- Shift 16 bits then load -> len_err pulse, data_out unchanged (32'hA0A0A0AF), bit_cnt=0. Repeat with 33 bits -> bit_cnt=33 before load, then len_err.
- Shift 10 bits, stop ser_clk for TIMEOUT+10 cycles -> timeout_err pulse at TIMEOUT, bit_cnt=0. A following full 32-bit frame commits correctly.
- Align a 32nd ser_clk edge with the load edge in the same synchronised cycle -> len_err (count=31), bit dropped. Hold load_data high 50 cycles -> only one pulse.
- Assert rst_n=0 after 20 bits -> all outputs 0 asynchronously. After release, a clean 32'h0000FFFF frame commits with word_cnt=1.
